// File: rtl/spi_slave_core.sv
// SPI slave core: 2-flop synchronized pins, all four SPI modes, 8/16/24/32-bit words,
// valid/ready TX and RX word streams with one-cycle overrun and underrun pulses.
module spi_slave_core (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        cpol_i,
  input  logic        cpha_i,
  input  logic        lsb_i,
  input  logic [1:0]  dsize_i,
  input  logic        spi_sck_i,
  input  logic        spi_nss_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_en_o,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] rx_data_o,
  output logic        busy_o,
  output logic        ovr_o,
  output logic        udr_o
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [1:0]  sck_sync_q, nss_sync_q, mosi_sync_q;
  logic        sck_prev_q, nss_prev_q;
  logic [0:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic        reload_pend_q, reload_pend_d;
  logic        rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
  logic        ovr_q, ovr_d, udr_q, udr_d;

  logic        sck_s, nss_s, mosi_s, active;
  logic        sck_edge, lead_edge, trail_edge, nss_fall, nss_rise;
  logic        start, stop, sample, shift_edge, word_done, tx_shift, tx_reload;
  logic [4:0]  last_idx;
  logic [31:0] rx_shift;

  assign sck_s      = sck_sync_q[1];
  assign nss_s      = nss_sync_q[1];
  assign mosi_s     = mosi_sync_q[1];
  assign active     = (state_q == ACTIVE);
  assign sck_edge   = sck_s ^ sck_prev_q;
  assign lead_edge  = sck_edge & (sck_s != cpol_i);
  assign trail_edge = sck_edge & (sck_s == cpol_i);
  assign nss_fall   = nss_prev_q & ~nss_s;
  assign nss_rise   = ~nss_prev_q & nss_s;
  assign start      = ~active & en_i & nss_fall;
  assign stop       = active & (~en_i | nss_rise);
  assign sample     = active & ~stop & (cpha_i ? trail_edge : lead_edge);
  assign shift_edge = active & ~stop & (cpha_i ? lead_edge : trail_edge);
  assign last_idx   = {dsize_i, 3'b111};
  assign word_done  = sample & (cnt_q == last_idx);
  // A shift edge seen with the count at zero is the word boundary (cpha=0) or the first leading edge (cpha=1).
  assign tx_shift   = shift_edge & (cnt_q != 5'd0);
  assign tx_reload  = start | (active & ~stop &
                      (cpha_i ? reload_pend_q : (shift_edge & (cnt_q == 5'd0))));

  always_comb begin
    rx_shift           = rx_sr_q >> 1;
    rx_shift[last_idx] = mosi_s;
    if (!lsb_i) rx_shift = {rx_sr_q[30:0], mosi_s};
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    reload_pend_d = 1'b0;
    rx_valid_d    = rx_valid_q;
    rx_data_d     = rx_data_q;
    ovr_d         = 1'b0;
    tx_ready_d    = tx_reload & tx_valid_i;
    udr_d         = tx_reload & ~tx_valid_i;
    if (start) state_d = ACTIVE;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
      rx_sr_d = '0;
    end else if (sample) begin
      cnt_d         = word_done ? 5'd0 : 5'(cnt_q + 5'd1);
      rx_sr_d       = word_done ? '0 : rx_shift;
      reload_pend_d = word_done & cpha_i;
    end
    if (tx_reload)     tx_sr_d = tx_valid_i ? tx_data_i : '0;
    else if (tx_shift) tx_sr_d = lsb_i ? (tx_sr_q >> 1) : (tx_sr_q << 1);
    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (word_done) begin
      if (rx_valid_q && !rx_ready_i) begin
        ovr_d = 1'b1;
      end else begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_shift;
      end
    end
    if (!en_i) begin
      rx_valid_d = 1'b0;
      cnt_d      = 5'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync_q    <= 2'b00;
      nss_sync_q    <= 2'b11;
      mosi_sync_q   <= 2'b00;
      sck_prev_q    <= 1'b0;
      nss_prev_q    <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= 5'd0;
      tx_sr_q       <= '0;
      rx_sr_q       <= '0;
      rx_data_q     <= '0;
      reload_pend_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      ovr_q         <= 1'b0;
      udr_q         <= 1'b0;
    end else begin
      sck_sync_q    <= {sck_sync_q[0], spi_sck_i};
      nss_sync_q    <= {nss_sync_q[0], spi_nss_i};
      mosi_sync_q   <= {mosi_sync_q[0], spi_mosi_i};
      sck_prev_q    <= sck_s;
      nss_prev_q    <= nss_s;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_sr_q       <= tx_sr_d;
      rx_sr_q       <= rx_sr_d;
      rx_data_q     <= rx_data_d;
      reload_pend_q <= reload_pend_d;
      rx_valid_q    <= rx_valid_d;
      tx_ready_q    <= tx_ready_d;
      ovr_q         <= ovr_d;
      udr_q         <= udr_d;
    end
  end

  assign spi_miso_o    = lsb_i ? tx_sr_q[0] : tx_sr_q[last_idx];
  assign spi_miso_en_o = active;
  assign busy_o        = active;
  assign tx_ready_o    = tx_ready_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_data_o     = rx_data_q;
  assign ovr_o         = ovr_q;
  assign udr_o         = udr_q;
endmodule
